alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Command sequencer between the UART byte receiver/transmitter and the shared ALU datapath.
- Collects a 3-byte command frame from the RX byte stream: opcode, operand A, operand B.
- Latches the operands, issues one ALU operation, waits for completion, and returns the 16-bit result as two TX bytes, MSB first.
- Handles bad opcodes, inter-byte timeouts and RX overruns.

Parameters:
- NUM_OPS, 8, number of valid opcodes. Opcode values 0..NUM_OPS-1 are legal.
- TIMEOUT_CYC, 50000, maximum number of idle clock cycles allowed between bytes of a frame.
- ERR_BYTE, 8'hEE, byte transmitted in response to an illegal opcode.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data is valid; holds until tx_ready
- tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready
- alu_op  out  8  latched opcode
- alu_a  out  8  latched operand A
- alu_b  out  8  latched operand B
- alu_start  out  1  one-cycle pulse that starts the ALU
- alu_done  in  1  ALU result is valid
- alu_result  in  16  ALU result
- busy  out  1  high in every state except IDLE
- err_timeout  out  1  one-cycle pulse when a frame is aborted by timeout
- overrun  out  1  sticky flag; cleared only by rst

Behaviour:
- Reset: on any clk edge with rst=1 (including mid-frame or mid-send), force the following:
  - state=IDLE
  - all outputs 0: tx_data, tx_valid, alu_op, alu_a, alu_b, alu_start, busy, err_timeout, overrun
  - timeout counter=0, result register=0
- States: IDLE, GET_A, GET_B, EXEC, WAIT, SEND_HI, SEND_LO, SEND_ERR.
- IDLE:
  - rx_valid with rx_data < NUM_OPS: latch alu_op, go to GET_A.
  - rx_valid with rx_data >= NUM_OPS: go to SEND_ERR.
- GET_A: rx_valid latches alu_a, go to GET_B.
- GET_B: rx_valid latches alu_b, go to EXEC.
- Timeout:
  - The counter is cleared on entry to GET_A/GET_B and on every accepted byte.
  - It increments on each cycle without rx_valid.
  - When it reaches TIMEOUT_CYC-1 without rx_valid: err_timeout=1 for one cycle, return to IDLE, discard the partial frame (alu_* registers keep their old values).
  - If rx_valid and expiry coincide, the byte wins.
- EXEC: alu_start=1 for exactly one cycle, then go to WAIT.
  - If the B byte is accepted at cycle N, alu_start is high at cycle N+1.
- WAIT:
  - alu_done is sampled only in WAIT.
  - On alu_done, latch alu_result and go to SEND_HI.
  - alu_done high during EXEC is ignored.
  - No ALU watchdog: the ALU must assert done.
- SEND_HI:
  - tx_data=result[15:8], tx_valid=1.
  - On a cycle with tx_valid && tx_ready, go to SEND_LO, and the next cycle presents result[7:0].
  - tx_valid is deasserted only after the final handshake; back-to-back bytes keep tx_valid=1 continuously.
- SEND_LO: on handshake go to IDLE with tx_valid=0 the next cycle.
- SEND_ERR: tx_data=ERR_BYTE, tx_valid=1; on handshake go to IDLE.
- tx_data and tx_valid are stable while tx_valid=1 && tx_ready=0.
- Overrun:
  - rx_valid in EXEC, WAIT, SEND_HI, SEND_LO or SEND_ERR drops the byte and sets overrun=1.
  - The dropped byte is never interpreted as an opcode.
- alu_op, alu_a and alu_b remain stable from latch until the next frame overwrites them.
- Minimum frame-to-response latency with an ALU that completes in one cycle and tx_ready held at 1: first tx_valid 3 cycles after the B byte.

Test Plan:
- Reset, then RX 0x02,0x12,0x34, ALU returns 0x0046 two cycles after alu_start -> alu_op=2, alu_a=0x12, alu_b=0x34, alu_start pulse at B+1, TX bytes 0x00 then 0x46, busy falls after the second handshake.
- RX opcode 0x09 (NUM_OPS=8) -> no alu_start, TX 0xEE once, return to IDLE; then a valid frame 0x01,0xFF,0x01 with result 0x0100 -> TX 0x01, 0x00.
- Use TIMEOUT_CYC=16. RX 0x03,0x05, then silence -> err_timeout pulses exactly 16 cycles after the 0x05 byte, state IDLE; the next byte 0x03 is treated as an opcode.
- RX a byte during WAIT and during SEND_HI with tx_ready=0 -> overrun=1 and stays set, the bytes are ignored, the response is unaffected; overrun clears only after rst.
- Hold tx_ready=0 for 10 cycles in SEND_HI -> tx_data=MSB and tx_valid=1 stay stable, no advance; on release, the LSB follows on the next cycle.
- Assert rst in WAIT and again in SEND_LO -> all outputs 0 on the following cycle, state IDLE; a late alu_done after reset has no effect.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: collects an opcode/A/B frame from the UART RX byte
// stream, runs one ALU operation and returns the 16-bit result as two TX
// bytes, MSB first. Illegal opcodes are answered with a single error byte.
// A stalled frame is abandoned after an inter-byte timeout. Bytes that arrive
// while a command is in flight are dropped and recorded in a sticky overrun flag.
module alu_cmd_sequencer #(
  parameter int          NUM_OPS     = 8,
  parameter int          TIMEOUT_CYC = 50000,
  parameter logic [7:0]  ERR_BYTE    = 8'hEE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        busy,
  output logic        err_timeout,
  output logic        overrun
);

  localparam int              CNT_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [8:0]      OPS_LIM = 9'(NUM_OPS);

  typedef enum logic [2:0] {
    IDLE, GET_A, GET_B, EXEC, WAIT, SEND_HI, SEND_LO, SEND_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       op_q, a_q, b_q;
  logic [15:0]      result_q;
  logic             overrun_q;

  logic opLegal;
  logic timeoutHit;
  logic dropByte;

  assign opLegal    = ({1'b0, rx_data} < OPS_LIM);
  assign timeoutHit = !rx_valid && (cnt_q == CNT_MAX);
  assign dropByte   = rx_valid && (state_q inside {EXEC, WAIT, SEND_HI, SEND_LO, SEND_ERR});

  // State and inter-byte timeout counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; the counter stays zero everywhere except while idling inside a frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (rx_valid) state_d = opLegal ? GET_A : SEND_ERR;
      end
      GET_A: begin
        if (rx_valid)        state_d = GET_B;
        else if (timeoutHit) state_d = IDLE;
        else                 cnt_d   = cnt_q + CNT_W'(1);
      end
      GET_B: begin
        if (rx_valid)        state_d = EXEC;
        else if (timeoutHit) state_d = IDLE;
        else                 cnt_d   = cnt_q + CNT_W'(1);
      end
      EXEC:     state_d = WAIT;
      WAIT:     if (alu_done) state_d = SEND_HI;
      SEND_HI:  if (tx_ready) state_d = SEND_LO;
      SEND_LO:  if (tx_ready) state_d = IDLE;
      SEND_ERR: if (tx_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Frame fields, ALU result and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (state_q == IDLE  && rx_valid && opLegal) op_q <= rx_data;
      if (state_q == GET_A && rx_valid)            a_q  <= rx_data;
      if (state_q == GET_B && rx_valid)            b_q  <= rx_data;
      if (state_q == WAIT  && alu_done)            result_q <= alu_result;
      if (dropByte)                                overrun_q <= 1'b1;
    end
  end

  // Outputs decoded from the current state only, so they hold steady during TX stalls.
  always_comb begin
    tx_data     = '0;
    tx_valid    = 1'b0;
    alu_start   = 1'b0;
    err_timeout = 1'b0;
    busy        = (state_q != IDLE);
    case (state_q)
      GET_A, GET_B: err_timeout = timeoutHit;
      EXEC:         alu_start   = 1'b1;
      SEND_HI: begin
        tx_data  = result_q[15:8];
        tx_valid = 1'b1;
      end
      SEND_LO: begin
        tx_data  = result_q[7:0];
        tx_valid = 1'b1;
      end
      SEND_ERR: begin
        tx_data  = ERR_BYTE;
        tx_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_op  = op_q;
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: transaction-level model of frames, ALU
// results and expected TX bytes, with directed scenarios and random frames.
module tb_alu_cmd_sequencer;

  localparam int         NumOps     = 8;
  localparam int         TimeoutCyc = 16;
  localparam logic [7:0] ErrByte    = 8'hEE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  alu_op, alu_a, alu_b;
  logic        alu_start;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = '0;
  logic        busy, err_timeout, overrun;

  int checks = 0;
  int failures = 0;

  int cycNum = 0, startCount = 0, startCyc = -1, timeoutCount = 0, timeoutCyc = -1;
  int hsCount = 0, lastHsCyc = -1, firstValidCyc = -1, bCyc = -1, idleCyc = -1;
  int aluWait = 0, aluLatency = 1, txReadyMode = 0;
  bit aluNoise = 1'b0;
  logic rstVal = 1'b1;
  logic [15:0] aluPending = '0;
  logic [23:0] expFrames[$];
  logic [7:0]  expTx[$];
  logic        prevValid = 1'b0, prevReady = 1'b0;
  logic [7:0]  prevData = '0;

  alu_cmd_sequencer #(
    .NUM_OPS(NumOps), .TIMEOUT_CYC(TimeoutCyc), .ERR_BYTE(ErrByte)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result),
    .busy(busy), .err_timeout(err_timeout), .overrun(overrun)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout actual=still running required=finished");
    $fatal(1, "[TB] time limit");
  end

  // The external ALU as the bench sees it: op<4 adds, otherwise multiplies.
  function automatic logic [15:0] aluModel(input logic [7:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    if (int'(op) < 4) return 16'(a) + 16'(b);
    return 16'(a) * 16'(b);
  endfunction

  // One clock cycle: drive inputs after the edge, then observe at the falling edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d);
    logic [23:0] f;
    logic [7:0]  e;
    @(posedge clk); #1;
    rst      = rstVal;
    rx_valid = v;
    rx_data  = d;
    if (aluWait > 0) begin
      alu_done   = (aluWait == 1);
      alu_result = (aluWait == 1) ? aluPending : 16'($urandom);
      aluWait--;
    end else begin
      alu_done   = aluNoise ? 1'($urandom_range(0, 1)) : 1'b0;
      alu_result = 16'($urandom);
    end
    case (txReadyMode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
    cycNum++;
    @(negedge clk);
    if (alu_start === 1'b1) begin
      startCount++;
      startCyc = cycNum;
      checks++;
      if (expFrames.size() == 0) begin
        failures++;
        $display("[TB] FAIL spurious_alu_start actual op=%h a=%h b=%h required=no start",
                 alu_op, alu_a, alu_b);
      end else begin
        f = expFrames.pop_front();
        if ({alu_op, alu_a, alu_b} !== f) begin
          failures++;
          $display("[TB] FAIL alu_operands actual=%h required=%h", {alu_op, alu_a, alu_b}, f);
        end
        aluPending = aluModel(f[23:16], f[15:8], f[7:0]);
        aluWait    = aluLatency;
        expTx.push_back(aluPending[15:8]);
        expTx.push_back(aluPending[7:0]);
      end
    end
    if (err_timeout === 1'b1) begin
      timeoutCount++;
      timeoutCyc = cycNum;
    end
    if (prevValid === 1'b1 && prevReady !== 1'b1) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== prevData) begin
        failures++;
        $display("[TB] FAIL tx_hold actual valid=%b data=%h required valid=1 data=%h",
                 tx_valid, tx_data, prevData);
      end
    end
    if (tx_valid === 1'b1 && prevValid !== 1'b1) firstValidCyc = cycNum;
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      hsCount++;
      lastHsCyc = cycNum;
      checks++;
      if (expTx.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_tx actual=%h required=no byte", tx_data);
      end else begin
        e = expTx.pop_front();
        if (tx_data !== e) begin
          failures++;
          $display("[TB] FAIL tx_byte actual=%h required=%h", tx_data, e);
        end
      end
    end
    prevValid = tx_valid;
    prevReady = tx_ready;
    prevData  = tx_data;
  endtask

  // Send a frame with optional idle gaps; illegal opcodes end after one byte.
  task automatic sendFrame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int gapA, input int gapB);
    applyStimulus(1'b1, op);
    if (int'(op) >= NumOps) begin
      expTx.push_back(ErrByte);
      return;
    end
    expFrames.push_back({op, a, b});
    repeat (gapA) applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b1, a);
    repeat (gapB) applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b1, b);
    bCyc = cycNum;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      applyStimulus(1'b0, 8'h00);
      n++;
      if (busy === 1'b0 && expTx.size() == 0 && expFrames.size() == 0) done = 1'b1;
    end
    idleCyc = cycNum;
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL wait_idle actual busy=%b pending_tx=%0d pending_frames=%0d required=idle",
               busy, expTx.size(), expFrames.size());
    end
  endtask

  task automatic doReset();
    rstVal = 1'b1;
    applyStimulus(1'b0, 8'h00);
    rstVal = 1'b0;
    expFrames.delete();
    expTx.delete();
    prevValid = 1'b0;
    applyStimulus(1'b0, 8'h00);
    checks++;
    if ({tx_data, tx_valid, alu_op, alu_a, alu_b, alu_start, busy, err_timeout, overrun} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs actual tx=%h v=%b op=%h a=%h b=%h st=%b busy=%b to=%b ov=%b required=all 0",
               tx_data, tx_valid, alu_op, alu_a, alu_b, alu_start, busy, err_timeout, overrun);
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    doReset();
  endtask

  task automatic test_basic();
    int s0, h0;
    $display("[TB] test_basic");
    txReadyMode = 0;
    aluLatency  = 2;
    s0 = startCount;
    h0 = hsCount;
    sendFrame(8'h02, 8'h12, 8'h34, 0, 0);
    waitIdle(50);
    checks++;
    if (startCyc != bCyc + 1) begin
      failures++;
      $display("[TB] FAIL start_timing actual=%0d required=%0d", startCyc, bCyc + 1);
    end
    checks++;
    if (startCount - s0 != 1 || hsCount - h0 != 2) begin
      failures++;
      $display("[TB] FAIL basic_counts actual starts=%0d bytes=%0d required starts=1 bytes=2",
               startCount - s0, hsCount - h0);
    end
    checks++;
    if (firstValidCyc != bCyc + 4) begin
      failures++;
      $display("[TB] FAIL basic_latency actual=%0d required=%0d", firstValidCyc, bCyc + 4);
    end
    checks++;
    if (idleCyc != lastHsCyc + 1) begin
      failures++;
      $display("[TB] FAIL busy_fall actual=%0d required=%0d", idleCyc, lastHsCyc + 1);
    end
  endtask

  task automatic test_min_latency();
    $display("[TB] test_min_latency");
    txReadyMode = 0;
    aluLatency  = 1;
    sendFrame(8'h07, 8'h10, 8'h10, 0, 0);
    waitIdle(50);
    checks++;
    if (firstValidCyc != bCyc + 3) begin
      failures++;
      $display("[TB] FAIL min_latency actual=%0d required=%0d", firstValidCyc, bCyc + 3);
    end
  endtask

  task automatic test_bad_opcode();
    int s0, h0;
    $display("[TB] test_bad_opcode");
    txReadyMode = 0;
    aluLatency  = 1;
    s0 = startCount;
    h0 = hsCount;
    sendFrame(8'h09, 8'h00, 8'h00, 0, 0);
    waitIdle(50);
    checks++;
    if (startCount != s0 || hsCount - h0 != 1) begin
      failures++;
      $display("[TB] FAIL bad_opcode actual starts=%0d bytes=%0d required starts=0 bytes=1",
               startCount - s0, hsCount - h0);
    end
    sendFrame(8'h01, 8'hFF, 8'h01, 0, 0);
    waitIdle(50);
  endtask

  task automatic test_timeout();
    int c5, t0;
    $display("[TB] test_timeout");
    txReadyMode = 0;
    aluLatency  = 1;
    t0 = timeoutCount;
    applyStimulus(1'b1, 8'h03);
    applyStimulus(1'b1, 8'h05);
    c5 = cycNum;
    repeat (20) applyStimulus(1'b0, 8'h00);
    checks++;
    if (timeoutCount - t0 != 1 || timeoutCyc != c5 + TimeoutCyc) begin
      failures++;
      $display("[TB] FAIL timeout_pulse actual count=%0d cyc=%0d required count=1 cyc=%0d",
               timeoutCount - t0, timeoutCyc, c5 + TimeoutCyc);
    end
    checks++;
    if (busy !== 1'b0 || alu_op !== 8'h03 || alu_a !== 8'h05 || alu_b !== 8'h01) begin
      failures++;
      $display("[TB] FAIL timeout_state actual busy=%b op=%h a=%h b=%h required busy=0 op=03 a=05 b=01",
               busy, alu_op, alu_a, alu_b);
    end
    sendFrame(8'h03, 8'h10, 8'h20, TimeoutCyc - 1, TimeoutCyc - 1);
    waitIdle(50);
    checks++;
    if (timeoutCount - t0 != 1) begin
      failures++;
      $display("[TB] FAIL timeout_boundary actual count=%0d required=1", timeoutCount - t0);
    end
  endtask

  task automatic test_stall();
    logic [15:0] r;
    int n;
    $display("[TB] test_stall");
    r = aluModel(8'h05, 8'h37, 8'h29);
    txReadyMode = 2;
    aluLatency  = 1;
    sendFrame(8'h05, 8'h37, 8'h29, 0, 0);
    n = 0;
    while (tx_valid !== 1'b1 && n < 20) begin
      applyStimulus(1'b0, 8'h00);
      n++;
    end
    repeat (10) begin
      applyStimulus(1'b0, 8'h00);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== r[15:8]) begin
        failures++;
        $display("[TB] FAIL stall_msb actual valid=%b data=%h required valid=1 data=%h",
                 tx_valid, tx_data, r[15:8]);
      end
    end
    txReadyMode = 0;
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== r[7:0]) begin
      failures++;
      $display("[TB] FAIL stall_lsb actual valid=%b data=%h required valid=1 data=%h",
               tx_valid, tx_data, r[7:0]);
    end
    waitIdle(50);
  endtask

  task automatic test_overrun();
    int n, t0;
    $display("[TB] test_overrun");
    txReadyMode = 0;
    aluLatency  = 5;
    t0 = timeoutCount;
    sendFrame(8'h04, 8'h11, 8'h22, 0, 0);
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b0, 8'h00);
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("[TB] FAIL overrun_wait actual=%b required=1", overrun);
    end
    txReadyMode = 2;
    n = 0;
    while (tx_valid !== 1'b1 && n < 20) begin
      applyStimulus(1'b0, 8'h00);
      n++;
    end
    applyStimulus(1'b1, 8'h02);
    txReadyMode = 0;
    waitIdle(50);
    repeat (20) applyStimulus(1'b0, 8'h00);
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b0 || timeoutCount != t0) begin
      failures++;
      $display("[TB] FAIL overrun_sticky actual ov=%b busy=%b timeouts=%0d required ov=1 busy=0 timeouts=0",
               overrun, busy, timeoutCount - t0);
    end
    doReset();
  endtask

  task automatic test_reset_midframe();
    int h0, n;
    logic [15:0] r;
    $display("[TB] test_reset_midframe");
    txReadyMode = 0;
    aluLatency  = 8;
    sendFrame(8'h06, 8'h03, 8'h04, 0, 0);
    repeat (3) applyStimulus(1'b0, 8'h00);
    doReset();
    h0 = hsCount;
    repeat (10) applyStimulus(1'b0, 8'h00);
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || hsCount != h0) begin
      failures++;
      $display("[TB] FAIL late_done actual busy=%b valid=%b bytes=%0d required busy=0 valid=0 bytes=0",
               busy, tx_valid, hsCount - h0);
    end
    r = aluModel(8'h02, 8'h40, 8'h41);
    txReadyMode = 2;
    aluLatency  = 1;
    sendFrame(8'h02, 8'h40, 8'h41, 0, 0);
    n = 0;
    while (tx_valid !== 1'b1 && n < 20) begin
      applyStimulus(1'b0, 8'h00);
      n++;
    end
    txReadyMode = 0;
    applyStimulus(1'b0, 8'h00);
    txReadyMode = 2;
    applyStimulus(1'b0, 8'h00);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== r[7:0]) begin
      failures++;
      $display("[TB] FAIL send_lo_hold actual valid=%b data=%h required valid=1 data=%h",
               tx_valid, tx_data, r[7:0]);
    end
    doReset();
    txReadyMode = 0;
  endtask

  task automatic test_random();
    int t0;
    logic [7:0] op, a, b;
    $display("[TB] test_random");
    t0 = timeoutCount;
    txReadyMode = 1;
    aluNoise    = 1'b1;
    for (int i = 0; i < 30; i++) begin
      op = 8'($urandom_range(0, 9));
      a  = 8'($urandom);
      b  = 8'($urandom);
      aluLatency = $urandom_range(1, 6);
      sendFrame(op, a, b, $urandom_range(0, TimeoutCyc - 1), $urandom_range(0, TimeoutCyc - 1));
      waitIdle(200);
      repeat ($urandom_range(0, 3)) applyStimulus(1'b0, 8'h00);
    end
    aluNoise    = 1'b0;
    txReadyMode = 0;
    checks++;
    if (timeoutCount != t0 || overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL random_flags actual timeouts=%0d ov=%b required timeouts=0 ov=0",
               timeoutCount - t0, overrun);
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    test_reset();
    test_basic();
    test_min_latency();
    test_bad_opcode();
    test_timeout();
    test_stall();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
